// File: rtl/vga_palette_ram_if.sv
// vga_palette_ram_if: pixel lookup and palette write bundle for vga_palette_ram.
//
// Signals (names match the block's pin list):
//   i_valid    lookup request this cycle
//   i_index    palette index to look up
//   i_blank    pixel outside active area, force black
//   i_wr_en    palette write strobe
//   i_wr_addr  entry to write
//   i_wr_data  colour to store
//   o_color    registered looked-up colour
//   o_valid    o_color belongs to a lookup issued two cycles earlier
//   o_ready    initialisation finished, writes are accepted
//
// Modports: master drives requests (pixel pipeline / CPU side), slave is the palette.
interface vga_palette_ram_if #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned COLOR_W = 9
);

  logic               i_valid;
  logic [INDEX_W-1:0] i_index;
  logic               i_blank;
  logic               i_wr_en;
  logic [INDEX_W-1:0] i_wr_addr;
  logic [COLOR_W-1:0] i_wr_data;
  logic [COLOR_W-1:0] o_color;
  logic               o_valid;
  logic               o_ready;

  modport master (
    output i_valid,
    output i_index,
    output i_blank,
    output i_wr_en,
    output i_wr_addr,
    output i_wr_data,
    input  o_color,
    input  o_valid,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_index,
    input  i_blank,
    input  i_wr_en,
    input  i_wr_addr,
    input  i_wr_data,
    output o_color,
    output o_valid,
    output o_ready
  );

endinterface

// File: rtl/vga_palette_ram.sv
// vga_palette_ram: register-based colour palette for a VGA pixel pipeline.
//
// After reset an INIT phase clears one entry per cycle (ENTRIES cycles), then
// the block enters RUN where palette writes are accepted. Pixel lookups run
// through a two-stage pipeline at one lookup per cycle in both phases.
//
// Ports:
//   i_clk    single rising-edge clock
//   i_rst_n  asynchronous active-low reset (storage is not reset, INIT clears it)
//   bus      vga_palette_ram_if.slave, see the interface file for signal list
//
// Build option:
//   VGA_PALETTE_BYPASS_EN  defined   -> read-during-write returns the new data
//                          undefined -> read-during-write returns the old data
//   Blanking wins over bypass in both builds.
module vga_palette_ram #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned COLOR_W = 9
) (
  input logic              i_clk,
  input logic              i_rst_n,
  vga_palette_ram_if.slave bus
);

  localparam int unsigned ENTRIES = 2 ** INDEX_W;
  localparam logic [INDEX_W-1:0] LastIdx = INDEX_W'(ENTRIES - 1);

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  // ---------------------------------------------------------------------------
  // Init / run control
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [INDEX_W-1:0] init_cnt_q, init_cnt_d;
  logic               ready_q, ready_d;
  logic               init_we;
  logic               run_we;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we    = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastIdx) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
      end
    endcase
    // Registered from the next state so o_ready rises on the first RUN cycle.
    ready_d = (state_d == StRun);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
    end
  end

  // Writes arriving during INIT are dropped.
  assign run_we = (state_q == StRun) && bus.i_wr_en;

  // ---------------------------------------------------------------------------
  // Storage: deliberately without reset, INIT does the clearing.
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0] mem_q [ENTRIES];

  always_ff @(posedge i_clk) begin
    if (init_we) begin
      mem_q[init_cnt_q] <= '0;
    end else if (run_we) begin
      mem_q[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup pipeline
  // ---------------------------------------------------------------------------
  logic               s1_valid_q;
  logic [INDEX_W-1:0] s1_index_q;
  logic               s1_blank_q;
  logic [COLOR_W-1:0] rd_data;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_index_q <= '0;
      s1_blank_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.i_valid;
      s1_index_q <= bus.i_index;
      s1_blank_q <= bus.i_blank;
    end
  end

  always_comb begin
    rd_data = mem_q[s1_index_q];
`ifdef VGA_PALETTE_BYPASS_EN
    // Forward a RUN write that hits the entry being read this cycle.
    if (run_we && (bus.i_wr_addr == s1_index_q)) begin
      rd_data = bus.i_wr_data;
    end
`endif
    // o_color holds while no lookup completes.
    color_d = color_q;
    if (s1_valid_q) begin
      color_d = s1_blank_q ? '0 : rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      color_q <= '0;
      valid_q <= 1'b0;
    end else begin
      color_q <= color_d;
      valid_q <= s1_valid_q;
    end
  end

  assign bus.o_color = color_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ready = ready_q;

endmodule

// File: tb/tb_vga_palette_ram.sv
// tb_vga_palette_ram: randomized and directed bench for vga_palette_ram with a
// behavioural palette model (array of colours plus per-entry "known" flags,
// edge count since reset, list of outstanding lookups).
module tb_vga_palette_ram;

  localparam int unsigned IW = 4;
  localparam int unsigned CW = 9;
  localparam int unsigned N  = 16;
`ifdef VGA_PALETTE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_palette_ram_if #(.INDEX_W(IW), .COLOR_W(CW)) bus_if ();

  vga_palette_ram #(.INDEX_W(IW), .COLOR_W(CW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model state
  logic [CW-1:0] mem_m [N];
  bit            known [N];
  int            cyc;          // clock edges since reset release, saturating at N
  bit            pend_v;       // lookup issued on the previous edge
  logic [IW-1:0] pend_i;
  bit            pend_b;
  bit            exp_v;
  bit            exp_r;
  logic [CW-1:0] exp_c;
  bit            exp_ck;       // expected colour is determined

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Effect of one clock edge, from the behavioural rules.
  task automatic model_edge(input bit v, input logic [IW-1:0] idx, input bit bl,
                            input bit we, input logic [IW-1:0] wa, input logic [CW-1:0] wd);
    bit running;
    running = (cyc >= N);
    exp_v   = pend_v;
    if (pend_v) begin
      if (pend_b) begin
        exp_c  = '0;
        exp_ck = 1'b1;
      end else if (Byp && running && we && (wa == pend_i)) begin
        exp_c  = wd;
        exp_ck = 1'b1;
      end else begin
        exp_c  = mem_m[pend_i];
        exp_ck = known[pend_i];
      end
    end
    if (!running) begin
      mem_m[cyc] = '0;
      known[cyc] = 1'b1;
    end else if (we) begin
      mem_m[wa] = wd;
      known[wa] = 1'b1;
    end
    pend_v = v;
    pend_i = idx;
    pend_b = bl;
    if (cyc < N) cyc++;
    exp_r = (cyc >= N);
  endtask

  // Called at a falling edge; drives inputs for one cycle and checks outputs.
  task automatic step(input bit v, input logic [IW-1:0] idx, input bit bl,
                      input bit we, input logic [IW-1:0] wa, input logic [CW-1:0] wd);
    bus_if.i_valid   = v;
    bus_if.i_index   = idx;
    bus_if.i_blank   = bl;
    bus_if.i_wr_en   = we;
    bus_if.i_wr_addr = wa;
    bus_if.i_wr_data = wd;
    @(posedge clk);
    model_edge(v, idx, bl, we, wa, wd);
    @(negedge clk);
    check("o_valid", {31'b0, bus_if.o_valid}, {31'b0, exp_v});
    check("o_ready", {31'b0, bus_if.o_ready}, {31'b0, exp_r});
    if (exp_ck) check("o_color", 32'(bus_if.o_color), 32'(exp_c));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Called at a falling edge; reset must act without waiting for a clock.
  task automatic do_reset();
    bus_if.i_valid = 1'b0;
    bus_if.i_wr_en = 1'b0;
    bus_if.i_blank = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_o_valid", {31'b0, bus_if.o_valid}, 32'd0);
    check("rst_o_color", 32'(bus_if.o_color), 32'd0);
    check("rst_o_ready", {31'b0, bus_if.o_ready}, 32'd0);
    pend_v = 1'b0;
    cyc    = 0;
    exp_v  = 1'b0;
    exp_r  = 1'b0;
    exp_c  = '0;
    exp_ck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      known[i] = 1'b0;
      mem_m[i] = '0;
    end
    pend_v = 1'b0; pend_i = '0; pend_b = 1'b0;
    bus_if.i_valid = 1'b0; bus_if.i_index = '0; bus_if.i_blank = 1'b0;
    bus_if.i_wr_en = 1'b0; bus_if.i_wr_addr = '0; bus_if.i_wr_data = '0;
    @(negedge clk);
    do_reset();

    // Ready stays low for exactly 16 cycles after release.
    for (int k = 1; k <= 16; k++) begin
      idle();
      if (k == 1)  check("ready_c1", {31'b0, bus_if.o_ready}, 32'd0);
      if (k == 15) check("ready_c15", {31'b0, bus_if.o_ready}, 32'd0);
      if (k == 16) check("ready_c16", {31'b0, bus_if.o_ready}, 32'd1);
    end

    // Every entry reads black after INIT.
    for (int i = 0; i < 18; i++) begin
      step(i < 16, IW'(i), 1'b0, 1'b0, '0, '0);
      if (i >= 1 && i <= 16) begin
        check("init_clear_valid", {31'b0, bus_if.o_valid}, 32'd1);
        check("init_clear_color", 32'(bus_if.o_color), 32'd0);
      end
    end

    // Write then look up entry 3.
    step(1'b0, '0, 1'b0, 1'b1, 4'd3, 9'h1E7);
    step(1'b1, 4'd3, 1'b0, 1'b0, '0, '0);
    idle();
    check("lat2_valid", {31'b0, bus_if.o_valid}, 32'd1);
    check("lat2_color", 32'(bus_if.o_color), 32'h1E7);

    // Fill palette, then stream all indices with blank on index 5.
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b1, IW'(i), CW'($urandom));
    step(1'b0, '0, 1'b0, 1'b1, 4'd5, 9'h1AA);
    for (int i = 0; i < 18; i++) begin
      step(i < 16, IW'(i), i == 5, 1'b0, '0, '0);
      if (i >= 1 && i <= 16) check("stream_valid", {31'b0, bus_if.o_valid}, 32'd1);
      if (i == 6) check("stream_blank5", 32'(bus_if.o_color), 32'd0);
    end

    // Read-during-write on entry 7.
    step(1'b0, '0, 1'b0, 1'b1, 4'd7, 9'h027);
    step(1'b1, 4'd7, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 4'd7, 9'h1FF);
    check("rdw_entry7", 32'(bus_if.o_color), Byp ? 32'h1FF : 32'h027);
    step(1'b1, 4'd7, 1'b0, 1'b0, '0, '0);
    idle();
    check("rdw_after", 32'(bus_if.o_color), 32'h1FF);

    // Blank beats a same-cycle write to the read entry.
    step(1'b0, '0, 1'b0, 1'b1, 4'd8, 9'h0AB);
    step(1'b1, 4'd8, 1'b1, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 4'd8, 9'h055);
    check("blank_prio", 32'(bus_if.o_color), 32'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, IW'($urandom), $urandom_range(0, 7) == 0,
             $urandom_range(0, 9) < 3, IW'($urandom), CW'($urandom));
      end
    end
    for (int k = 0; k < 20; k++) idle();

    // Write during INIT is dropped.
    step(1'b0, '0, 1'b0, 1'b1, 4'd2, 9'h1C3);
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) step(1'b0, '0, 1'b0, 1'b1, 4'd2, 9'h00B);
      else idle();
    end
    step(1'b1, 4'd2, 1'b0, 1'b0, '0, '0);
    idle();
    check("init_wr_drop", 32'(bus_if.o_color), 32'd0);

    // Reset with a lookup in flight.
    step(1'b0, '0, 1'b0, 1'b1, 4'd9, 9'h155);
    step(1'b1, 4'd9, 1'b0, 1'b0, '0, '0);
    step(1'b1, 4'd9, 1'b0, 1'b0, '0, '0);
    check("pre_rst_color", 32'(bus_if.o_color), 32'h155);
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      idle();
      if (k == 1)  check("flight_dropped", {31'b0, bus_if.o_valid}, 32'd0);
      if (k == 16) check("ready_again", {31'b0, bus_if.o_ready}, 32'd1);
    end
    step(1'b1, 4'd9, 1'b0, 1'b0, '0, '0);
    idle();
    check("cleared_after_rst", 32'(bus_if.o_color), 32'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
